pio_irq_servicer: RTL and testbench

Hardware Avalon-MM initiator that services the 4-bit pushbutton PIO's edge-capture interrupt without CPU involvement. It sits on the master side of that PIO's s1 port. At reset it programs the PIO interrupt mask. On each `irq` it reads and clears the edge-capture register, then hands the captured bit mask to downstream logic through a small valid/ready event FIFO. A programmable hold-off after each service acts as a debounce window.

---
 rtl/pio_irq_pkg.sv | 32 +++
 rtl/pio_event_fifo.sv | 67 ++++++
 rtl/pio_irq_servicer.sv | 199 +++++++++++++++++++
 tb/tb_pio_irq_servicer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_irq_pkg.sv
// Shared types and constants for the PIO edge-capture interrupt servicer.
// Holds the service FSM encoding, the PIO register map and small helpers.
package pio_irq_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_CLR  = 3'd4,
    ST_PUSH = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam logic [31:0] EDGE_CLEAR_ALL = 32'hFFFF_FFFF;

  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pio_event_fifo.sv
// Small register-based event FIFO; head is presented directly from storage.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pio_event_fifo
  import pio_irq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign head    = empty ? {WIDTH{1'b0}} : mem[rd_ptr[AW-1:0]];

  // Storage write; full+pop overwrites the slot being retired this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end else begin
      mem <= mem;
    end
  end

  // Read and write pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
    end
  end

endmodule

// File: rtl/pio_irq_servicer.sv
// Avalon-MM initiator that services a PIO edge-capture interrupt in hardware
// and forwards each captured edge mask through a valid/ready event FIFO.
module pio_irq_servicer
  import pio_irq_pkg::*;
#(
  parameter int               WIDTH          = 4,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT  = 4'hF,
  parameter int               FIFO_DEPTH     = 4,
  parameter int               HOLDOFF_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             irq,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [WIDTH-1:0] ev_data,
  output logic             overflow,
  output logic [7:0]       drop_count,
  input  logic             ovf_clear
);

  localparam logic [31:0] MASK_WORD = 32'(IRQ_MASK_INIT);
  localparam bit          HOLD_EN   = (HOLDOFF_CYCLES > 0);
  localparam logic [31:0] HOLD_LOAD = HOLD_EN ? 32'(HOLDOFF_CYCLES - 1) : 32'd0;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] capture;
  logic [31:0]      hold_cnt;
  logic             cs_next;
  logic             wn_next;
  logic [1:0]       addr_next;
  logic [31:0]      wdata_next;
  logic             has_event;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic             unused_readdata;

  assign unused_readdata = ^m_readdata;

  // Next-state logic; INIT lingers one cycle until its mask write is on the bus.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: begin
        if (m_chipselect) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (irq) begin
          state_next = ST_RD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD:   state_next = ST_CAP;
      ST_CAP:  state_next = ST_CLR;
      ST_CLR:  state_next = ST_PUSH;
      ST_PUSH: begin
        if (HOLD_EN) begin
          state_next = ST_HOLD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == 32'd0) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Bus cycle decoded from the upcoming state so the registered outputs line up with it.
  always_comb begin
    cs_next    = 1'b0;
    wn_next    = 1'b1;
    addr_next  = PIO_ADDR_DATA;
    wdata_next = 32'd0;
    case (state_next)
      ST_INIT: begin
        cs_next    = 1'b1;
        wn_next    = 1'b0;
        addr_next  = PIO_ADDR_MASK;
        wdata_next = MASK_WORD;
      end
      ST_RD: begin
        cs_next   = 1'b1;
        addr_next = PIO_ADDR_EDGE;
      end
      ST_CLR: begin
        cs_next    = 1'b1;
        wn_next    = 1'b0;
        addr_next  = PIO_ADDR_EDGE;
        wdata_next = EDGE_CLEAR_ALL;
      end
      default: begin
        cs_next    = 1'b0;
        wn_next    = 1'b1;
        addr_next  = PIO_ADDR_DATA;
        wdata_next = 32'd0;
      end
    endcase
  end

  // State and bus output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= PIO_ADDR_DATA;
      m_writedata  <= 32'd0;
    end else begin
      state        <= state_next;
      m_chipselect <= cs_next;
      m_write_n    <= wn_next;
      m_address    <= addr_next;
      m_writedata  <= wdata_next;
    end
  end

  // Edge mask sampled one cycle after the read cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture <= {WIDTH{1'b0}};
    end else if (state == ST_CAP) begin
      capture <= m_readdata[WIDTH-1:0];
    end else begin
      capture <= capture;
    end
  end

  // Debounce hold-off counter, loaded as the service completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= 32'd0;
    end else if ((state == ST_PUSH) && HOLD_EN) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == ST_HOLD) && (hold_cnt != 32'd0)) begin
      hold_cnt <= hold_cnt - 32'd1;
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

  // A zero capture is a spurious interrupt and produces no event.
  assign has_event = (state == ST_PUSH) && (capture != {WIDTH{1'b0}});
  assign fifo_pop  = ev_valid && ev_ready;
  assign fifo_push = has_event;
  assign drop      = has_event && fifo_full && !fifo_pop;
  assign ev_valid  = !fifo_empty;

  // Sticky overflow flag and drop counter; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (ovf_clear) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc8(drop_count);
    end else begin
      overflow   <= overflow;
      drop_count <= drop_count;
    end
  end

  pio_event_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(capture),
    .pop      (fifo_pop),
    .head     (ev_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: a behavioural PIO model answers the bus, and an
// event queue with drop bookkeeping predicts FIFO contents and overflow state.
module tb_pio_irq_servicer;

  localparam int HOLD  = 10;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        irq;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        ovf_clear;

  int checks = 0;
  int errors = 0;

  // PIO model state and stimulus handles
  logic [3:0] pio_edge = 4'h0;
  logic [3:0] pio_mask = 4'h0;
  logic [3:0] edge_in  = 4'h0;
  logic       spur     = 1'b0;

  // bus monitor records (label = cycle index of the bus cycle)
  int cyc = 0;
  int n_rd = 0, n_clr = 0, n_mask = 0, n_other = 0;
  int last_rd_cyc = 0, last_clr_cyc = 0, last_mask_cyc = 0;
  logic [1:0]  last_rd_addr = 2'd0;
  logic [31:0] last_clr_data = 32'd0, last_mask_data = 32'd0;

  // reference model
  int exp_q[$];
  bit m_ovf = 1'b0;
  int m_drops = 0;

  pio_irq_servicer #(
    .WIDTH(4), .IRQ_MASK_INIT(4'hF), .FIFO_DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .irq(irq), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .overflow(overflow), .drop_count(drop_count), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  assign irq = (|(pio_edge & pio_mask)) | spur;

  // PIO s1 behaviour: clear has priority over newly arriving edges
  always @(posedge clk) begin
    if (m_chipselect && !m_write_n && m_address == 2'd3)
      pio_edge <= pio_edge & ~m_writedata[3:0];
    else
      pio_edge <= pio_edge | edge_in;
    if (m_chipselect && !m_write_n && m_address == 2'd2)
      pio_mask <= m_writedata[3:0];
    if (m_chipselect && m_write_n && m_address == 2'd3)
      m_readdata <= {28'h0, pio_edge} | ($urandom & 32'hFFFF_FFF0);
    else
      m_readdata <= $urandom;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect) begin
      if (m_write_n) begin
        n_rd <= n_rd + 1; last_rd_cyc <= cyc; last_rd_addr <= m_address;
      end else if (m_address == 2'd2) begin
        n_mask <= n_mask + 1; last_mask_cyc <= cyc; last_mask_data <= m_writedata;
      end else if (m_address == 2'd3) begin
        n_clr <= n_clr + 1; last_clr_cyc <= cyc; last_clr_data <= m_writedata;
      end else begin
        n_other <= n_other + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    check("rst_cs",    {31'h0, m_chipselect}, 32'd0);
    check("rst_wn",    {31'h0, m_write_n},    32'd1);
    check("rst_addr",  {30'h0, m_address},    32'd0);
    check("rst_wdata", m_writedata,           32'd0);
    check("rst_valid", {31'h0, ev_valid},     32'd0);
    check("rst_data",  {28'h0, ev_data},      32'd0);
    check("rst_ovf",   {31'h0, overflow},     32'd0);
    check("rst_drops", {24'h0, drop_count},   32'd0);
  endtask

  task automatic wait_rd(input int target);
    int t = 0;
    while (n_rd < target && t < 300) begin @(negedge clk); t++; end
    check("rd_seen", {31'h0, n_rd >= target}, 32'd1);
  endtask

  task automatic wait_clr(input int target);
    int t = 0;
    while (n_clr < target && t < 300) begin @(negedge clk); t++; end
    check("clr_seen", {31'h0, n_clr >= target}, 32'd1);
  endtask

  task automatic pulse_edge(input logic [3:0] mask);
    edge_in = mask;
    @(negedge clk);
    edge_in = 4'h0;
  endtask

  // One full service; ev_ready / ovf_clear are optionally raised during the push cycle.
  task automatic service(input logic [3:0] mask, input bit rdy, input bit oclr);
    int  tgt;
    bit  popped;
    tgt = n_clr + 1;
    pulse_edge(mask);
    wait_clr(tgt);
    ev_ready  = rdy;
    ovf_clear = oclr;
    popped = 1'b0;
    if (rdy && exp_q.size() > 0) begin
      check("push_head", {28'h0, ev_data}, 32'(exp_q[0]));
      void'(exp_q.pop_front());
      popped = 1'b1;
    end
    if (mask != 4'h0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(int'(mask));
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (oclr) begin m_ovf = 1'b0; m_drops = 0; end
    @(negedge clk);
    ev_ready  = 1'b0;
    ovf_clear = 1'b0;
    repeat (HOLD + 3) @(negedge clk);
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("drain_valid", {31'h0, ev_valid}, 32'd1);
      check("drain_data",  {28'h0, ev_data},  32'(exp_q[0]));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    ev_ready = 1'b0;
    check("drain_empty", {31'h0, ev_valid}, 32'd0);
  endtask

  task automatic chk_ovf();
    check("ovf",   {31'h0, overflow},   {31'h0, m_ovf});
    check("drops", {24'h0, drop_count}, 32'(m_drops));
  endtask

  initial begin
    int c0, rd1, tr, tc, nm, nr;
    reset_n = 1'b0; ev_ready = 1'b0; ovf_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    c0 = cyc;
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    check("init_wr_count", 32'(n_mask), 32'd1);
    check("init_wr_cycle", 32'(last_mask_cyc), 32'(c0 + 1));
    check("init_wr_data",  last_mask_data, 32'h0000_000F);
    check("idle_no_rd",    32'(n_rd + n_clr + n_other), 32'd0);
    check("idle_wn",       {31'h0, m_write_n}, 32'd1);
    check("idle_addr",     {30'h0, m_address}, 32'd0);

    // directed service of 0x4 and hold-off spacing
    c0 = cyc;
    pulse_edge(4'h4);
    wait_rd(1);
    check("rd_cycle", 32'(last_rd_cyc), 32'(c0 + 2));
    check("rd_addr",  {30'h0, last_rd_addr}, 32'd3);
    rd1 = last_rd_cyc;
    while (cyc < rd1 + 3) @(negedge clk);
    check("clr_cycle", 32'(last_clr_cyc), 32'(rd1 + 2));
    check("clr_data",  last_clr_data, 32'hFFFF_FFFF);
    check("valid_early", {31'h0, ev_valid}, 32'd0);
    edge_in = 4'h2;
    @(negedge clk);
    edge_in = 4'h0;
    check("valid_k5", {31'h0, ev_valid}, 32'd1);
    check("data_k5",  {28'h0, ev_data}, 32'h4);
    exp_q.push_back(4);
    wait_rd(2);
    check("holdoff_spacing", 32'(last_rd_cyc), 32'(rd1 + 15));
    wait_clr(2);
    exp_q.push_back(2);
    repeat (HOLD + 4) @(negedge clk);
    drain();

    // spurious interrupt: clear happens, nothing pushed
    tr = n_rd + 1; tc = n_clr + 1;
    spur = 1'b1;
    wait_rd(tr);
    spur = 1'b0;
    wait_clr(tc);
    check("spur_clr_data", last_clr_data, 32'hFFFF_FFFF);
    repeat (HOLD + 4) @(negedge clk);
    check("spur_no_event", {31'h0, ev_valid}, 32'd0);

    // overflow with six events, then clear, then clear beating a drop
    for (int i = 1; i <= 6; i++) service(4'(i), 1'b0, 1'b0);
    check("ovf_set",   {31'h0, overflow},   32'd1);
    check("drop_two",  {24'h0, drop_count}, 32'd2);
    chk_ovf();
    ovf_clear = 1'b1; @(negedge clk); ovf_clear = 1'b0;
    m_ovf = 1'b0; m_drops = 0;
    chk_ovf();
    service(4'h7, 1'b0, 1'b1);
    check("clr_prio_ovf", {31'h0, overflow}, 32'd0);
    chk_ovf();
    drain();

    // full FIFO with a pop during the push cycle
    for (int i = 1; i <= 4; i++) service(4'(i), 1'b0, 1'b0);
    service(4'h5, 1'b1, 1'b0);
    chk_ovf();
    drain();

    // randomized rounds against the reference model
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(2, 7);
      for (int i = 0; i < n; i++)
        service(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      chk_ovf();
      drain();
      ovf_clear = 1'b1; @(negedge clk); ovf_clear = 1'b0;
      m_ovf = 1'b0; m_drops = 0;
    end

    // reset while in CAP, with FIFO full and overflow set
    for (int i = 0; i < 5; i++) service(4'($urandom_range(1, 15)), 1'b0, 1'b0);
    chk_ovf();
    nm = n_mask; nr = n_rd; tc = n_clr + 1;
    pulse_edge(4'h8);
    wait_rd(nr + 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete(); m_ovf = 1'b0; m_drops = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_clr(tc);
    check("reinit_mask", 32'(n_mask), 32'(nm + 1));
    check("reinit_data", last_mask_data, 32'h0000_000F);
    exp_q.push_back(8);
    repeat (HOLD + 6) @(negedge clk);
    check("reservice_reads", 32'(n_rd), 32'(nr + 2));
    chk_ovf();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
